// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 raster timing master for the dinosaur game display.
//
// Generates the pixel tick and the scan coordinates consumed by the sprite
// renderers, takes their pixel bits back one pixel period later, composites
// them by priority and drives the VGA connector.
//
// Ports
//   CLK       in   1   system clock
//   RESET     in   1   asynchronous reset, active low
//   px_fg     in   1   foreground (dinosaur) pixel from renderer
//   px_bg     in   1   background-layer (obstacle/ground) pixel
//   row_addr  out  9   current scan line, 511 during vertical blanking
//   col_addr  out  10  current scan column
//   fresh     out  1   high during visible lines; falling edge = frame strobe
//   pix_tick  out  1   one-CLK pulse at each pixel boundary
//   video_on  out  1   current address is inside the visible area
//   hs        out  1   horizontal sync, active low
//   vs        out  1   vertical sync, active low
//   rgb       out  12  {R[3:0],G[3:0],B[3:0]}
//
// Optional build macro
//   VGA_SCAN_TEST_PATTERN_EN  replaces the sky colour with 128-column colour
//                             bars (F00,0F0,00F,FF0,0FF) for alignment checks.
//
// Counter widths assume H_TOTAL and V_TOTAL both fit in 10 bits.

`timescale 1ns/1ps

module vga_scan #(
  parameter int          CLK_DIV   = 4,
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [11:0] FG_RGB    = 12'h333,
  parameter logic [11:0] BG_RGB    = 12'h777,
  parameter logic [11:0] SKY_RGB   = 12'hFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        px_fg,
  input  logic        px_bg,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        fresh,
  output logic        pix_tick,
  output logic        video_on,
  output logic        hs,
  output logic        vs,
  output logic [11:0] rgb
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             adv;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [8:0]       row_q, row_d;
  logic             vid_q, vid_d;
  logic             fresh_q, fresh_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [11:0]      rgb_q, rgb_d;
  logic [11:0]      sky;

  // Colour for an empty visible pixel. Indexed by the column of the pixel
  // being output (the registered h_q, one pixel behind the next address).
`ifdef VGA_SCAN_TEST_PATTERN_EN
  always_comb begin
    case (h_q[9:7])
      3'd0:    sky = 12'hF00;
      3'd1:    sky = 12'h0F0;
      3'd2:    sky = 12'h00F;
      3'd3:    sky = 12'hFF0;
      3'd4:    sky = 12'h0FF;
      default: sky = SKY_RGB;
    endcase
  end
`else
  assign sky = SKY_RGB;
`endif

  always_comb begin
    // Counters advance on the edge that ends the pixel period. Using div_q
    // directly (rather than the registered tick) keeps CLK_DIV=1 advancing
    // from the very first edge after reset.
    adv    = (div_q == DIV_LAST);
    div_d  = adv ? '0 : div_q + 1'b1;
    tick_d = (div_d == DIV_LAST);

    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Address-side outputs are registered from the next counter values so
    // they stay aligned with h_q/v_q.
    vid_d   = (h_d < H_VIS) && (v_d < V_VIS);
    fresh_d = (v_d < V_VIS);
    row_d   = (v_d < V_VIS) ? v_d[8:0] : 9'h1FF;

    // Output pipeline: at the end of a pixel period, render the pixel whose
    // addresses were on the bus during that period.
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (adv) begin
      hs_d = !((h_q >= HS_START) && (h_q < HS_END));
      vs_d = !((v_q >= VS_START) && (v_q < VS_END));
      if (!vid_q) begin
        rgb_d = 12'h000;
      end else if (px_fg) begin
        rgb_d = FG_RGB;
      end else if (px_bg) begin
        rgb_d = BG_RGB;
      end else begin
        rgb_d = sky;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      row_q   <= '0;
      vid_q   <= 1'b1;
      fresh_q <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      h_q     <= h_d;
      v_q     <= v_d;
      row_q   <= row_d;
      vid_q   <= vid_d;
      fresh_q <= fresh_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pix_tick = tick_q;
  assign col_addr = h_q;
  assign row_addr = row_q;
  assign video_on = vid_q;
  assign fresh    = fresh_q;
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign rgb      = rgb_q;

endmodule

// File: tb/tb_vga_scan.sv
`timescale 1ns/1ps

module tb_vga_scan;

  // Instance 0: CLK_DIV=4 with a shrunk raster so whole frames fit the run.
  // Instance 1: CLK_DIV=1 with the full 800-pixel line and a short frame.
  typedef struct {
    int d; int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb;
  } tim_t;

  tim_t T0 = '{4, 40, 4, 8, 6, 20, 3, 2, 4};
  tim_t T1 = '{1, 640, 16, 96, 48, 6, 1, 2, 1};

  localparam int FRAME0 = 58 * 29 * 4;   // CLK per frame of instance 0

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fg0 = 1'b0, bg0 = 1'b0, fg1 = 1'b0, bg1 = 1'b0;
  logic [8:0]  row0, row1;
  logic [9:0]  col0, col1;
  logic        fresh0, fresh1, tick0, tick1, vid0, vid1, hs0, hs1, vs0, vs1;
  logic [11:0] rgb0, rgb1;

  int checks = 0;
  int errors = 0;
  int mode0 = 0;   // 0: stub renderer, 1: random pixels
  int mode1 = 0;   // 0: pixels held low, 1: random pixels

  always #5 clk = ~clk;

  vga_scan #(.CLK_DIV(4), .H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
             .V_VISIBLE(20), .V_FP(3), .V_SYNC(2), .V_BP(4)) u0 (
    .CLK(clk), .RESET(rst_n), .px_fg(fg0), .px_bg(bg0),
    .row_addr(row0), .col_addr(col0), .fresh(fresh0), .pix_tick(tick0),
    .video_on(vid0), .hs(hs0), .vs(vs0), .rgb(rgb0));

  vga_scan #(.CLK_DIV(1), .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u1 (
    .CLK(clk), .RESET(rst_n), .px_fg(fg1), .px_bg(bg1),
    .row_addr(row1), .col_addr(col1), .fresh(fresh1), .pix_tick(tick1),
    .video_on(vid1), .hs(hs1), .vs(vs1), .rgb(rgb1));

  wire [35:0] act0 = {row0, col0, fresh0, tick0, vid0, hs0, vs0, rgb0};
  wire [35:0] act1 = {row1, col1, fresh1, tick1, vid1, hs1, vs1, rgb1};
  localparam logic [35:0] RST_VEC = {9'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000};

  function automatic logic [11:0] sky_of(int col);
`ifdef VGA_SCAN_TEST_PATTERN_EN
    case (col / 128)
      0: return 12'hF00;
      1: return 12'h0F0;
      2: return 12'h00F;
      3: return 12'hFF0;
      4: return 12'h0FF;
      default: return 12'hFFF;
    endcase
`else
    return 12'hFFF;
`endif
  endfunction

  // Outputs expected after n clock edges since reset release. sfg/sbg are the
  // renderer bits present at the most recent pixel-boundary edge.
  function automatic logic [35:0] model(tim_t t, int n, logic sfg, logic sbg);
    int htot, vtot, p, h, v, hp, vp;
    logic [8:0] row;
    logic tick, hs_e, vs_e;
    logic [11:0] c;
    htot = t.hv + t.hf + t.hs + t.hb;
    vtot = t.vv + t.vf + t.vs + t.vb;
    p = n / t.d;
    h = p % htot;
    v = (p / htot) % vtot;
    row = (v < t.vv) ? 9'(v) : 9'd511;
    tick = (t.d == 1) ? (n >= 1) : ((n % t.d) == t.d - 1);
    hs_e = 1'b1;
    vs_e = 1'b1;
    c = 12'h000;
    if (p > 0) begin
      hp = (p - 1) % htot;
      vp = ((p - 1) / htot) % vtot;
      hs_e = !(hp >= t.hv + t.hf && hp < t.hv + t.hf + t.hs);
      vs_e = !(vp >= t.vv + t.vf && vp < t.vv + t.vf + t.vs);
      if (hp < t.hv && vp < t.vv)
        c = sfg ? 12'h333 : (sbg ? 12'h777 : sky_of(hp));
    end
    return {row, 10'(h), (v < t.vv), tick, (h < t.hv && v < t.vv), hs_e, vs_e, c};
  endfunction

  task automatic check_v(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_i(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Per-cycle compare, instance 0, plus its renderer stimulus.
  initial begin : chk0
    int n;
    logic sfg, sbg;
    n = 0; sfg = 1'b0; sbg = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) n = 0;
      else begin
        n++;
        if (n % T0.d == 0) begin sfg = fg0; sbg = bg0; end
      end
      @(negedge clk);
      if (!rst_n) begin n = 0; sfg = 1'b0; sbg = 1'b0; end
      check_v("scan0", act0, model(T0, n, sfg, sbg));
      if (mode0 == 0) begin
        fg0 = (col0 >= 10'd8 && col0 <= 10'd17 && row0 >= 9'd10 && row0 <= 9'd15);
        bg0 = (row0 >= 9'd14);
      end else begin
        fg0 = ($urandom_range(0, 1) == 1);
        bg0 = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin : chk1
    int n;
    logic sfg, sbg;
    n = 0; sfg = 1'b0; sbg = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) n = 0;
      else begin
        n++;
        if (n % T1.d == 0) begin sfg = fg1; sbg = bg1; end
      end
      @(negedge clk);
      if (!rst_n) begin n = 0; sfg = 1'b0; sbg = 1'b0; end
      check_v("scan1", act1, model(T1, n, sfg, sbg));
      if (mode1 == 0) begin
        fg1 = 1'b0; bg1 = 1'b0;
      end else begin
        fg1 = ($urandom_range(0, 1) == 1);
        bg1 = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Timing measurements on instance 0.
  int mon_cyc = 0;
  int hs_run = 0, hs_len = -1, hs_last_fall = -1, hs_period = -1;
  int vs_run = 0, vs_len = -1;
  int fr_last_fall = -1, fr_period = -1, fr_falls = 0;
  int row_at_fall = -1, row_before_fall = -1;
  int c333 = 0, c777 = 0;
  bit f1_done = 1'b0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_fr = 1'b1;
  logic [8:0] p_row = 9'd0;

  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_cyc = 0; hs_run = 0; vs_run = 0;
        hs_last_fall = -1; fr_last_fall = -1;
        p_hs = 1'b1; p_vs = 1'b1; p_fr = 1'b1; p_row = 9'd0;
      end else begin
        mon_cyc++;
        if (!hs0) hs_run++;
        else if (!p_hs) begin hs_len = hs_run; hs_run = 0; end
        if (!hs0 && p_hs) begin
          if (hs_last_fall >= 0) hs_period = mon_cyc - hs_last_fall;
          hs_last_fall = mon_cyc;
        end
        if (!vs0) vs_run++;
        else if (!p_vs) begin vs_len = vs_run; vs_run = 0; end
        if (!fresh0 && p_fr) begin
          fr_falls++;
          row_at_fall = int'(row0);
          row_before_fall = int'(p_row);
          if (fr_last_fall >= 0) fr_period = mon_cyc - fr_last_fall;
          fr_last_fall = mon_cyc;
        end
        if (!f1_done) begin
          if (rgb0 == 12'h333) c333++;
          if (rgb0 == 12'h777) c777++;
          if (mon_cyc == FRAME0) f1_done = 1'b1;
        end
        p_hs = hs0; p_vs = vs0; p_fr = fresh0; p_row = row0;
      end
    end
  end

  task automatic wait_col1(int col, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (col1 == 10'(col) && row1 < 9'd6) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cyc(int target);
    for (int i = 0; i < 40000 && mon_cyc < target; i++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin : ctrl
    bit ok;
    int k, falls0;
    logic [11:0] e0, e131, e300;
    #1 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_i("rst_hs", int'(hs0), 1);
    check_i("rst_vs", int'(vs0), 1);
    check_i("rst_rgb", int'(rgb0), 0);
    #2 rst_n = 1'b1;

    // Clock period in which the first tick appears; the release period is 1.
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tick0) begin k = i + 1; break; end
    end
    check_i("first_tick_clk", k, 4);

`ifdef VGA_SCAN_TEST_PATTERN_EN
    e0 = 12'hF00; e131 = 12'h0F0; e300 = 12'h00F;
`else
    e0 = 12'hFFF; e131 = 12'hFFF; e300 = 12'hFFF;
`endif
    wait_col1(1, ok);
    check_i("wait_col1_1", int'(ok), 1);
    check_i("bar_col0", int'(rgb1), int'(e0));
    check_i("tick1_high", int'(tick1), 1);
    wait_col1(131, ok);
    check_i("bar_col130", int'(rgb1), int'(e131));
    wait_col1(300, ok);
    check_i("bar_col299", int'(rgb1), int'(e300));
    wait_col1(641, ok);
    check_i("blank_col640", int'(rgb1), 0);
    mode1 = 1;

    wait_cyc(FRAME0 + 2);
    check_i("frame1_fg_clks", c333, 240);
    check_i("frame1_bg_clks", c777, 880);
    mode0 = 1;

    wait_cyc(3 * FRAME0);
    check_i("hs_low_clks", hs_len, 32);
    check_i("line_period", hs_period, 232);
    check_i("vs_low_clks", vs_len, 464);
    check_i("frame_period", fr_period, FRAME0);
    check_i("fresh_falls", fr_falls, 3);
    check_i("row_at_fall", row_at_fall, 511);
    check_i("row_before_fall", row_before_fall, 19);

    // Asynchronous reset in the middle of a visible line.
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (row0 == 9'd10 && col0 == 10'd30) begin ok = 1'b1; break; end
    end
    check_i("wait_row10_col30", int'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    check_v("async_rst0", act0, RST_VEC);
    check_v("async_rst1", act1, RST_VEC);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    falls0 = fr_falls;
    wait_cyc(3000);
    check_i("no_spurious_fall", fr_falls - falls0, 0);
    wait_cyc(7000);
    check_i("fall_after_restart", fr_falls - falls0, 1);
    check_i("restart_fall_row", row_at_fall, 511);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
